// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory read/write channel among NUM_CONSUMERS
// requesters, one transaction in flight at a time, all outputs registered.
//
// state      | meaning
// IDLE       | scan consumers from rr_ptr, grant first pending request
// READ_WAIT  | memory read issued, waiting for mem_read_ready
// WRITE_WAIT | memory write issued, waiting for mem_write_ready
// RESPOND    | consumer ready held until its valid drops
module mem_arbiter #(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic                               mem_read_valid,
    output logic [ADDR_BITS-1:0]               mem_read_address,
    input  logic                               mem_read_ready,
    input  logic [DATA_BITS-1:0]               mem_read_data,
    output logic                               mem_write_valid,
    output logic [ADDR_BITS-1:0]               mem_write_address,
    output logic [DATA_BITS-1:0]               mem_write_data,
    input  logic                               mem_write_ready
);

    localparam int PTR_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        WRITE_WAIT,
        RESPOND
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   g;
    logic               serving_read;
    logic               scan_found;
    logic [PTR_W-1:0]   scan_idx;
    logic [PTR_W-1:0]   g_next;
    logic [NUM_CONSUMERS-1:0] pending;

    assign pending = consumer_read_valid | consumer_write_valid;
    assign g_next  = (g == PTR_W'(NUM_CONSUMERS - 1)) ? '0 : g + 1'b1;

    // Walk offsets high to low so the lowest offset from rr_ptr wins.
    always_comb begin
        int cand;
        scan_found = 1'b0;
        scan_idx   = '0;
        cand       = 0;
        for (int k = NUM_CONSUMERS - 1; k >= 0; k--) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_CONSUMERS) cand = cand - NUM_CONSUMERS;
            if (pending[PTR_W'(cand)]) begin
                scan_found = 1'b1;
                scan_idx   = PTR_W'(cand);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                <= IDLE;
            rr_ptr               <= '0;
            g                    <= '0;
            serving_read         <= 1'b0;
            consumer_read_ready  <= '0;
            consumer_read_data   <= '0;
            consumer_write_ready <= '0;
            mem_read_valid       <= 1'b0;
            mem_read_address     <= '0;
            mem_write_valid      <= 1'b0;
            mem_write_address    <= '0;
            mem_write_data       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (scan_found) begin
                        g <= scan_idx;
                        // Read takes precedence; a pending write gets a later grant.
                        if (consumer_read_valid[scan_idx]) begin
                            serving_read     <= 1'b1;
                            mem_read_valid   <= 1'b1;
                            mem_read_address <= consumer_read_address[scan_idx*ADDR_BITS +: ADDR_BITS];
                            state            <= READ_WAIT;
                        end else begin
                            serving_read      <= 1'b0;
                            mem_write_valid   <= 1'b1;
                            mem_write_address <= consumer_write_address[scan_idx*ADDR_BITS +: ADDR_BITS];
                            mem_write_data    <= consumer_write_data[scan_idx*DATA_BITS +: DATA_BITS];
                            state             <= WRITE_WAIT;
                        end
                    end
                end
                READ_WAIT: begin
                    if (mem_read_ready) begin
                        mem_read_valid                              <= 1'b0;
                        consumer_read_data[g*DATA_BITS +: DATA_BITS] <= mem_read_data;
                        consumer_read_ready[g]                      <= 1'b1;
                        state                                       <= RESPOND;
                    end
                end
                WRITE_WAIT: begin
                    if (mem_write_ready) begin
                        mem_write_valid         <= 1'b0;
                        consumer_write_ready[g] <= 1'b1;
                        state                   <= RESPOND;
                    end
                end
                RESPOND: begin
                    if (serving_read) begin
                        if (!consumer_read_valid[g]) begin
                            consumer_read_ready[g] <= 1'b0;
                            rr_ptr                 <= g_next;
                            state                  <= IDLE;
                        end
                    end else if (!consumer_write_valid[g]) begin
                        consumer_write_ready[g] <= 1'b0;
                        rr_ptr                  <= g_next;
                        state                   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected memory requests and consumer
// completions are queued as stimulus is driven and checked as the DUT emits them.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  rv, wv;
    logic [31:0] raddr, waddr;
    logic [63:0] wdata;
    logic [3:0]  cr_ready, cw_ready;
    logic [63:0] cr_data;
    logic        mem_read_valid, mem_write_valid;
    logic [7:0]  mem_read_address, mem_write_address;
    logic [15:0] mem_write_data;
    logic        mem_read_ready, mem_write_ready;
    logic [15:0] mem_read_data;
    logic [15:0] rd_data_drv;
    bit          use_model;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_write;
        int          idx;
        logic [7:0]  addr;
        logic [15:0] data;
    } exp_t;

    exp_t mem_exp[$];
    exp_t cons_exp[$];

    // Bench memory: either a fixed value or a function of the address.
    assign mem_read_data = use_model ? {~mem_read_address, mem_read_address} : rd_data_drv;

    mem_arbiter #(.NUM_CONSUMERS(4), .ADDR_BITS(8), .DATA_BITS(16)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (rv),
        .consumer_read_address  (raddr),
        .consumer_read_ready    (cr_ready),
        .consumer_read_data     (cr_data),
        .consumer_write_valid   (wv),
        .consumer_write_address (waddr),
        .consumer_write_data    (wdata),
        .consumer_write_ready   (cw_ready),
        .mem_read_valid         (mem_read_valid),
        .mem_read_address       (mem_read_address),
        .mem_read_ready         (mem_read_ready),
        .mem_read_data          (mem_read_data),
        .mem_write_valid        (mem_write_valid),
        .mem_write_address      (mem_write_address),
        .mem_write_data         (mem_write_data),
        .mem_write_ready        (mem_write_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model(input logic [7:0] a);
        return {~a, a};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_read(input int idx, input logic [7:0] a, input logic [15:0] d);
        mem_exp.push_back('{1'b0, idx, a, 16'h0});
        cons_exp.push_back('{1'b0, idx, a, d});
    endtask

    task automatic push_write(input int idx, input logic [7:0] a, input logic [15:0] d);
        mem_exp.push_back('{1'b1, idx, a, d});
        cons_exp.push_back('{1'b1, idx, a, d});
    endtask

    task automatic wait_for(input bit wr, input string name);
        bit ok = 0;
        for (int c = 0; c < 30 && !ok; c++) begin
            if ((wr ? mem_write_valid : mem_read_valid) === 1'b1) ok = 1;
            else tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: mem valid not seen within 30 cycles, required 1", name);
        end
    endtask

    // Monitor: pops expectations on rising mem valids / consumer readies.
    logic       prev_mrv, prev_mwv;
    logic [3:0] prev_rr, prev_wr;
    always @(negedge clk) begin
        if (!reset) begin
            prev_mrv = 0; prev_mwv = 0; prev_rr = 0; prev_wr = 0;
        end else begin
            exp_t e;
            logic [3:0] rise;
            checks++;
            if ((mem_read_valid && mem_write_valid) || $countones(cr_ready | cw_ready) > 1) begin
                errors++;
                $display("FAIL mon_exclusive: mrv=%b mwv=%b rr=%b wr=%b, required at most one active",
                         mem_read_valid, mem_write_valid, cr_ready, cw_ready);
            end
            if (mem_read_valid && !prev_mrv) begin
                checks++;
                if (mem_exp.size() == 0) begin
                    errors++;
                    $display("FAIL mon_mem_read: unexpected read addr=%h, required none", mem_read_address);
                end else begin
                    e = mem_exp.pop_front();
                    if (e.is_write || mem_read_address !== e.addr) begin
                        errors++;
                        $display("FAIL mon_mem_read: got read addr=%h, required write=%0b addr=%h",
                                 mem_read_address, e.is_write, e.addr);
                    end
                end
            end
            if (mem_write_valid && !prev_mwv) begin
                checks++;
                if (mem_exp.size() == 0) begin
                    errors++;
                    $display("FAIL mon_mem_write: unexpected write addr=%h, required none", mem_write_address);
                end else begin
                    e = mem_exp.pop_front();
                    if (!e.is_write || mem_write_address !== e.addr || mem_write_data !== e.data) begin
                        errors++;
                        $display("FAIL mon_mem_write: got addr=%h data=%h, required write=%0b addr=%h data=%h",
                                 mem_write_address, mem_write_data, e.is_write, e.addr, e.data);
                    end
                end
            end
            rise = (cr_ready & ~prev_rr) | (cw_ready & ~prev_wr);
            if (rise != 0) begin
                checks++;
                if (cons_exp.size() == 0) begin
                    errors++;
                    $display("FAIL mon_consumer: unexpected completion rr=%b wr=%b, required none", cr_ready, cw_ready);
                end else begin
                    e = cons_exp.pop_front();
                    if (e.is_write ? (cw_ready[e.idx] !== 1'b1 || (cw_ready & ~prev_wr) != (4'b1 << e.idx))
                                   : (cr_ready[e.idx] !== 1'b1 || (cr_ready & ~prev_rr) != (4'b1 << e.idx)
                                      || cr_data[e.idx*16 +: 16] !== e.data)) begin
                        errors++;
                        $display("FAIL mon_consumer: got rr=%b wr=%b data=%h, required write=%0b idx=%0d data=%h",
                                 cr_ready, cw_ready, cr_data[e.idx*16 +: 16], e.is_write, e.idx, e.data);
                    end
                end
            end
            prev_mrv = mem_read_valid; prev_mwv = mem_write_valid;
            prev_rr  = cr_ready;       prev_wr  = cw_ready;
        end
    end

    task automatic do_reset;
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        rv = 0; wv = 0; raddr = 0; waddr = 0; wdata = 0;
        mem_read_ready = 0; mem_write_ready = 0; rd_data_drv = 0; use_model = 0;
        reset = 1'b0;
        #7;
        checks++;
        if ({mem_read_valid, mem_write_valid, cr_ready, cw_ready} !== 10'h0 ||
            {mem_read_address, mem_write_address, mem_write_data, cr_data} !== 96'h0) begin
            errors++;
            $display("FAIL reset_outputs: mrv=%b mwv=%b rr=%b wr=%b ra=%h wa=%h wd=%h rd=%h, required all 0",
                     mem_read_valid, mem_write_valid, cr_ready, cw_ready,
                     mem_read_address, mem_write_address, mem_write_data, cr_data);
        end
        tick(2);
        reset = 1'b1;
        tick(2);
        checks++;
        if ({mem_read_valid, mem_write_valid, cr_ready, cw_ready} !== 10'h0) begin
            errors++;
            $display("FAIL reset_idle: mrv=%b mwv=%b rr=%b wr=%b, required all 0",
                     mem_read_valid, mem_write_valid, cr_ready, cw_ready);
        end
    endtask

    task automatic test_single_read;
        rv[1] = 1'b1; raddr[15:8] = 8'hA5; rd_data_drv = 16'hBEEF;
        push_read(1, 8'hA5, 16'hBEEF);
        tick();
        checks++;
        if (mem_read_valid !== 1'b1 || mem_read_address !== 8'hA5) begin
            errors++;
            $display("FAIL read_grant: mrv=%b addr=%h, required 1 a5", mem_read_valid, mem_read_address);
        end
        tick();
        mem_read_ready = 1'b1;
        tick();
        mem_read_ready = 1'b0;
        checks++;
        if (cr_ready !== 4'b0010 || cr_data[31:16] !== 16'hBEEF || mem_read_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_complete: rr=%b data=%h mrv=%b, required 0010 beef 0",
                     cr_ready, cr_data[31:16], mem_read_valid);
        end
        tick();
        checks++;
        if (cr_ready !== 4'b0010) begin
            errors++;
            $display("FAIL read_hold: rr=%b, required 0010 while valid high", cr_ready);
        end
        rv[1] = 1'b0;
        tick();
        checks++;
        if (cr_ready !== 4'b0000 || cr_data[31:16] !== 16'hBEEF) begin
            errors++;
            $display("FAIL read_release: rr=%b data=%h, required 0000 beef", cr_ready, cr_data[31:16]);
        end
        tick();
    endtask

    task automatic test_single_write;
        wv[2] = 1'b1; waddr[23:16] = 8'h3C; wdata[47:32] = 16'hDEAD;
        push_write(2, 8'h3C, 16'hDEAD);
        wait_for(1'b1, "write_grant");
        waddr[23:16] = 8'h00; wdata[47:32] = 16'h0000;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (mem_write_valid !== 1'b1 || mem_write_address !== 8'h3C ||
                mem_write_data !== 16'hDEAD || cw_ready !== 4'b0) begin
                errors++;
                $display("FAIL write_wait: mwv=%b addr=%h data=%h wr=%b, required 1 3c dead 0000",
                         mem_write_valid, mem_write_address, mem_write_data, cw_ready);
            end
        end
        mem_write_ready = 1'b1;
        tick();
        mem_write_ready = 1'b0;
        checks++;
        if (cw_ready !== 4'b0100 || mem_write_valid !== 1'b0) begin
            errors++;
            $display("FAIL write_complete: wr=%b mwv=%b, required 0100 0", cw_ready, mem_write_valid);
        end
        wv[2] = 1'b0;
        tick();
        checks++;
        if (cw_ready !== 4'b0000) begin
            errors++;
            $display("FAIL write_release: wr=%b, required 0000", cw_ready);
        end
        tick();
    endtask

    task automatic test_fairness;
        int order[$];
        int done = 0;
        do_reset();
        use_model = 1; mem_read_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            raddr[i*8 +: 8] = 8'(16*i + 1);
            push_read(i, 8'(16*i + 1), model(8'(16*i + 1)));
        end
        push_read(0, 8'h01, model(8'h01));
        rv = 4'hF;
        for (int c = 0; c < 100 && done < 4; c++) begin
            tick();
            for (int i = 0; i < 4; i++)
                if (cr_ready[i] && rv[i]) begin rv[i] = 1'b0; order.push_back(i); done++; end
        end
        tick();
        rv = 4'hF;
        for (int c = 0; c < 50 && done < 5; c++) begin
            tick();
            for (int i = 0; i < 4; i++)
                if (cr_ready[i] && rv[i] && done < 5) begin rv = 4'h0; order.push_back(i); done++; end
        end
        checks++;
        if (done != 5) begin
            errors++;
            $display("FAIL fair_count: %0d grants seen, required 5", done);
        end
        for (int k = 0; k < order.size(); k++) begin
            checks++;
            if (order[k] != (k % 4)) begin
                errors++;
                $display("FAIL fair_order[%0d]: got consumer %0d, required %0d", k, order[k], k % 4);
            end
        end
        rv = 4'h0;
        tick(2);
        mem_read_ready = 1'b0; use_model = 0;
    endtask

    task automatic test_read_write_same;
        bit rd_done = 0;
        bit wr_done = 0;
        use_model = 1; mem_read_ready = 1'b1; mem_write_ready = 1'b1;
        raddr[7:0] = 8'h5A; waddr[7:0] = 8'h66; wdata[15:0] = 16'h1357;
        push_read(0, 8'h5A, model(8'h5A));
        push_write(0, 8'h66, 16'h1357);
        rv[0] = 1'b1; wv[0] = 1'b1;
        for (int c = 0; c < 50 && !(rd_done && wr_done); c++) begin
            tick();
            if (cr_ready[0] && rv[0]) begin rv[0] = 1'b0; rd_done = 1; end
            if (cw_ready[0] && wv[0]) begin
                wv[0] = 1'b0; wr_done = 1;
                checks++;
                if (!rd_done) begin
                    errors++;
                    $display("FAIL rw_order: write completed with read_done=%0b, required 1", rd_done);
                end
            end
        end
        checks++;
        if (!(rd_done && wr_done)) begin
            errors++;
            $display("FAIL rw_done: read=%0b write=%0b, required 1 1", rd_done, wr_done);
        end
        tick(2);
        mem_read_ready = 1'b0; mem_write_ready = 1'b0; use_model = 0;
    endtask

    task automatic test_reset_in_wait;
        rd_data_drv = 16'hCAFE;
        rv[2] = 1'b1; raddr[23:16] = 8'h77;
        mem_exp.push_back('{1'b0, 2, 8'h77, 16'h0});
        wait_for(1'b0, "rst_wait_grant");
        tick(2);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({mem_read_valid, mem_write_valid, cr_ready, cw_ready} !== 10'h0 ||
            {mem_read_address, mem_write_address, mem_write_data, cr_data} !== 96'h0) begin
            errors++;
            $display("FAIL rst_async: mrv=%b ra=%h rr=%b wr=%b rd=%h, required all 0",
                     mem_read_valid, mem_read_address, cr_ready, cw_ready, cr_data);
        end
        rv = 4'h0;
        tick();
        reset = 1'b1;
        mem_read_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (cr_ready !== 4'b0 || mem_read_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_no_completion: rr=%b mrv=%b, required 0000 0", cr_ready, mem_read_valid);
            end
        end
        mem_read_ready = 1'b0;
        tick();
    endtask

    task automatic test_stall;
        rd_data_drv = 16'h1234;
        rv[3] = 1'b1; raddr[31:24] = 8'h42;
        push_read(3, 8'h42, 16'h1234);
        wait_for(1'b0, "stall_grant");
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h42 || cr_ready !== 4'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: mrv=%b addr=%h rr=%b, required 1 42 0000",
                         c, mem_read_valid, mem_read_address, cr_ready);
            end
        end
        mem_read_ready = 1'b1;
        tick();
        mem_read_ready = 1'b0;
        checks++;
        if (cr_ready !== 4'b1000 || cr_data[63:48] !== 16'h1234) begin
            errors++;
            $display("FAIL stall_complete: rr=%b data=%h, required 1000 1234", cr_ready, cr_data[63:48]);
        end
        rv[3] = 1'b0;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_fairness();
        test_read_write_same();
        test_reset_in_wait();
        test_stall();
        checks++;
        if (mem_exp.size() != 0 || cons_exp.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d mem and %0d consumer expectations left, required 0 0",
                     mem_exp.size(), cons_exp.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_CONSUMERS, 4, number of requesting consumers sharing one memory channel.
REQ-002 Parameter ADDR_BITS, 8, memory address width.
REQ-003 Parameter DATA_BITS, 16, memory data width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 consumer_read_valid  input  NUM_CONSUMERS  per-consumer read request.
REQ-007 consumer_read_address  input  NUM_CONSUMERS*ADDR_BITS  packed read addresses, consumer i at bits [i*ADDR_BITS +: ADDR_BITS].
REQ-008 consumer_read_ready  output  NUM_CONSUMERS  per-consumer read completion.
REQ-009 consumer_read_data  output  NUM_CONSUMERS*DATA_BITS  packed read data, same packing rule.
REQ-010 consumer_write_valid  input  NUM_CONSUMERS  per-consumer write request.
REQ-011 consumer_write_address  input  NUM_CONSUMERS*ADDR_BITS  packed write addresses.
REQ-012 consumer_write_data  input  NUM_CONSUMERS*DATA_BITS  packed write data.
REQ-013 consumer_write_ready  output  NUM_CONSUMERS  per-consumer write completion.
REQ-014 mem_read_valid / mem_read_address  output  1 / ADDR_BITS  memory read request.
REQ-015 mem_read_ready / mem_read_data  input  1 / DATA_BITS  memory read acknowledge and data.
REQ-016 mem_write_valid / mem_write_address / mem_write_data  output  1 / ADDR_BITS / DATA_BITS  memory write request.
REQ-017 mem_write_ready  input  1  memory write acknowledge.

Function
REQ-018 All outputs SHALL be registered; FSM states IDLE, READ_WAIT, WRITE_WAIT, RESPOND; one transaction in flight at a time.
REQ-019 IDLE: arbiter SHALL scan consumers round-robin starting at rr_ptr, granting the first with read_valid or write_valid set; grant index g latched.
REQ-020 If consumer g has both read_valid and write_valid set, read SHALL be served first; the write is served on a later grant.
REQ-021 Read grant: at the granting edge mem_read_valid<=1, mem_read_address<=address of g, state<=READ_WAIT.
REQ-022 Write grant: at the granting edge mem_write_valid<=1, mem_write_address/data<=those of g, state<=WRITE_WAIT.
REQ-023 READ_WAIT: outputs held; on edge with mem_read_ready=1: mem_read_valid<=0, consumer_read_data[g]<=mem_read_data, consumer_read_ready[g]<=1, state<=RESPOND.
REQ-024 WRITE_WAIT: outputs held; on edge with mem_write_ready=1: mem_write_valid<=0, consumer_write_ready[g]<=1, state<=RESPOND.
REQ-025 RESPOND: ready[g] SHALL stay 1 until an edge sampling the corresponding valid[g]=0; at that edge ready[g]<=0, rr_ptr<=(g+1) mod NUM_CONSUMERS, state<=IDLE.
REQ-026 Minimum latency: request valid at edge k -> mem valid after edge k; mem ready at edge m -> consumer ready after edge m; at least one IDLE cycle between transactions.
REQ-027 Consumer inputs SHALL be ignored except at the granting edge (address/data latched) and for valid[g] in RESPOND.
REQ-028 consumer_read_data[i] SHALL hold its last value until overwritten by a new read for consumer i.
REQ-029 At most one bit of consumer_read_ready|consumer_write_ready SHALL be 1; mem_read_valid and mem_write_valid SHALL never both be 1.
REQ-030 mem ready asserted while the matching mem valid is 0 SHALL be ignored.
REQ-031 Requests dropped before grant are never served; no request queueing beyond the input valids.

Reset
REQ-032 reset=0 SHALL immediately (asynchronously) set state IDLE, rr_ptr 0, g 0, all ready/valid outputs 0, all address/data outputs 0.
REQ-033 Reset mid-transaction SHALL abandon it; no completion is signalled after reset release.

Verification
REQ-034 Single read: consumer 1 read addr 0xA5; mem returns 0xBEEF two cycles later -> mem_read_address=0xA5, consumer_read_ready[1]=1, slice 1 data=0xBEEF; ready drops one edge after valid drops.
REQ-035 Single write: consumer 2 writes 0xDEAD to 0x3C -> mem_write_valid=1, addr=0x3C, data=0xDEAD until mem_write_ready; then consumer_write_ready[2]=1.
REQ-036 Fairness: all 4 consumers hold read_valid continuously, mem_read_ready tied 1, each drops valid on ready -> grants in order 0,1,2,3; with valids re-raised, next grant after 3 is 0.
REQ-037 Read/write same consumer: consumer 0 raises both -> read completes first, then write, mem valids never overlap.
REQ-038 Reset in READ_WAIT: reset=0 mid-wait -> all outputs 0 immediately; after release, pending mem_read_ready pulse produces no consumer ready.
REQ-039 Stalled memory: mem_read_ready held 0 for 20 cycles -> mem_read_valid/address stable throughout, no consumer ready asserted.
